fcvt_result_stage: RTL and testbench
====================================

Name: fcvt_result_stage

Overview:
- Registered, buffered result stage directly downstream of the combinational float-to-int converter.
- Accepts converted integer and exception bits (p_lost, denorm, invalid) with a destination tag over a valid/ready handshake, and queues them in a small FIFO for the writeback port.
- Maintains sticky exception flags (FCSR-style) and saturating event counters.
- Canonicalises invalid results to 0x80000000.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- TAG_W, 5, destination register tag width.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  converter result present.
- in_ready  output  1  stage can accept; equals !full.
- in_d  input  32  converter integer result.
- in_p_lost  input  1  precision lost.
- in_denorm  input  1  source was denormalized.
- in_invalid  input  1  inf/NaN/out of range.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  writeback accepts head.
- out_d  output  32  head result.
- out_tag  output  TAG_W  head tag.
- out_flags  output  3  head flags {invalid, denorm, p_lost}.
- flag_clr  input  1  clear sticky flags.
- sticky_flags  output  3  {invalid, denorm, inexact}, sticky.
- cnt_invalid  output  CNT_W  count of accepted invalid results.
- cnt_inexact  output  CNT_W  count of accepted p_lost results.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Clears wr_ptr, rd_ptr, count, sticky_flags, cnt_invalid and cnt_inexact.
  - Results: out_valid=0, in_ready=1.
  - out_d, out_tag and out_flags read 0 while empty; they are registered zero at reset.
  - Reset mid-stream discards all queued entries. Pending flag_clr is irrelevant.
- Push: push = in_valid & in_ready. The entry is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Stored data: if in_invalid=1, store d=32'h80000000 regardless of in_d; otherwise store in_d unchanged.
- Stored flags: {in_invalid, in_denorm, in_p_lost} exactly as presented.
- Pop: pop = out_valid & out_ready. rd_ptr increments, wrapping modulo DEPTH.
- count update: count+1 on push only; count-1 on pop only; unchanged on simultaneous push and pop.
- Full (count==DEPTH): in_ready=0, so a push is impossible. A pop in that cycle frees a slot; in_ready rises the next cycle (no combinational ready path from out_ready).
- Empty (count==0):
  - out_valid=0 and out_ready is ignored.
  - There is no bypass: a push into an empty FIFO gives out_valid=1 the following cycle (latency 1).
- Ordering: strict FIFO. out_d, out_tag and out_flags are driven from the head entry and stay stable while out_valid=1 and out_ready=0.
- in_valid while in_ready=0: the stage holds no state change; the upstream must hold its inputs.
- Sticky flags: next = (flag_clr ? 0 : sticky_flags) | (push ? {in_invalid, in_denorm, in_p_lost} : 0). A push coinciding with flag_clr leaves only the new bits set.
- Counters: increment on push when the corresponding input bit is 1, and saturate at all-ones (no wrap). Counters are cleared only by rst, not by flag_clr.
- No combinational path from in_* to out_*; in_ready and out_valid are derived from count only.

Test Plan:
- Reset then single push of in_d=32'd3, all flags 0, tag 5 → out_valid=1 next cycle with out_d=3, out_tag=5, out_flags=000; out_ready=1 pops it; count returns to 0.
- Push with in_invalid=1 and in_d=32'd80000000 (decimal) → out_d=32'h80000000, out_flags=100, sticky_flags=100, cnt_invalid=1.
- out_ready=0 with DEPTH=2: push 7, then 9 → in_ready=0 and count=2. A third in_valid is not accepted. Then out_ready=1 → pops 7 then 9 in order; in_ready returns to 1 the cycle after the first pop.
- Simultaneous push and pop at count=1 → count stays 1, order preserved. Push with in_p_lost=1 in the same cycle as flag_clr=1 while sticky=110 → sticky becomes 001.
- Preload cnt_inexact near saturation (force, or CNT_W=2 build): push 4 inexact results → counter reads 3, no wrap.
- Mid-stream rst with 2 entries queued → next cycle count=0, out_valid=0, sticky_flags=0, counters=0, in_ready=1.

Source files
------------

// File: rtl/fcvt_result_stage.sv
// fcvt_result_stage
// Registered result buffer that sits after the combinational float-to-int
// converter. Converted results are queued in a small FIFO together with
// their exception bits and destination tag, and the writeback port drains
// them in order. The stage also keeps FCSR-style sticky exception flags and
// two saturating event counters.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  upstream handshake; in_ready = !full
//   in_d            converter integer result
//   in_p_lost       precision lost (inexact)
//   in_denorm       source operand was denormalized
//   in_invalid      inf/NaN/out-of-range source
//   in_tag          destination register tag
//   out_valid/ready writeback handshake; out_valid = !empty
//   out_d/tag/flags head entry, flags = {invalid, denorm, p_lost}
//   flag_clr        clear the sticky flags
//   sticky_flags    {invalid, denorm, inexact}, accumulated over pushes
//   cnt_invalid     saturating count of accepted invalid results
//   cnt_inexact     saturating count of accepted p_lost results
//   count           current FIFO occupancy
module fcvt_result_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_d,
    input  logic                     in_p_lost,
    input  logic                     in_denorm,
    input  logic                     in_invalid,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_d,
    output logic [TAG_W-1:0]         out_tag,
    output logic [2:0]               out_flags,
    input  logic                     flag_clr,
    output logic [2:0]               sticky_flags,
    output logic [CNT_W-1:0]         cnt_invalid,
    output logic [CNT_W-1:0]         cnt_inexact,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0] INVALID_RESULT = 32'h8000_0000;

    logic [31:0]      mem_d     [DEPTH];
    logic [TAG_W-1:0] mem_tag   [DEPTH];
    logic [2:0]       mem_flags [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshake signals come from the occupancy register only, so there is
    // no combinational path from out_ready to in_ready or from in_* to out_*.
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head entry is presented directly from storage; it is masked to zero
    // while the FIFO is empty so stale entries never leak onto the bus.
    assign out_d     = empty ? '0 : mem_d[rd_ptr];
    assign out_tag   = empty ? '0 : mem_tag[rd_ptr];
    assign out_flags = empty ? '0 : mem_flags[rd_ptr];

    // FIFO storage and pointers. Invalid conversions are canonicalised to
    // the most-negative integer on the way in, whatever the converter
    // produced. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i]     <= '0;
                mem_tag[i]   <= '0;
                mem_flags[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr]     <= in_invalid ? INVALID_RESULT : in_d;
                mem_tag[wr_ptr]   <= in_tag;
                mem_flags[wr_ptr] <= {in_invalid, in_denorm, in_p_lost};
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: the clear acts first, so bits from a push in the same
    // cycle as flag_clr survive while older bits are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (flag_clr ? 3'b000 : sticky_flags)
                          | (push ? {in_invalid, in_denorm, in_p_lost} : 3'b000);
        end
    end

    // Event counters saturate at all-ones and are cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_invalid <= '0;
            cnt_inexact <= '0;
        end else begin
            if (push && in_invalid && (cnt_invalid != {CNT_W{1'b1}})) begin
                cnt_invalid <= cnt_invalid + 1'b1;
            end
            if (push && in_p_lost && (cnt_inexact != {CNT_W{1'b1}})) begin
                cnt_inexact <= cnt_inexact + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_result_stage.sv
// Testbench for fcvt_result_stage. A queue-based reference model tracks the
// expected FIFO contents, sticky flags and counters; every cycle all DUT
// outputs are compared against it. Directed steps cover the key scenarios,
// followed by a randomized run. The counters are built narrow so that
// saturation is reached quickly.
module tb_fcvt_result_stage;

    localparam int DEPTH = 2;
    localparam int TAG_W = 5;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_d;
    logic                   in_p_lost;
    logic                   in_denorm;
    logic                   in_invalid;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_d;
    logic [TAG_W-1:0]       out_tag;
    logic [2:0]             out_flags;
    logic                   flag_clr;
    logic [2:0]             sticky_flags;
    logic [CNT_W-1:0]       cnt_invalid;
    logic [CNT_W-1:0]       cnt_inexact;
    logic [$clog2(DEPTH):0] count;

    fcvt_result_stage #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_d(in_d),
        .in_p_lost(in_p_lost),
        .in_denorm(in_denorm),
        .in_invalid(in_invalid),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_d(out_d),
        .out_tag(out_tag),
        .out_flags(out_flags),
        .flag_clr(flag_clr),
        .sticky_flags(sticky_flags),
        .cnt_invalid(cnt_invalid),
        .cnt_inexact(cnt_inexact),
        .count(count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] tag;
        logic [2:0]       flags;
    } entry_t;

    entry_t     model_q[$];
    logic [2:0] model_sticky;
    int         model_cnt_inv;
    int         model_cnt_inx;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's current state.
    task automatic checkOutput();
        int sz;
        sz = model_q.size();
        check("in_ready",  32'(in_ready),  32'(sz < DEPTH));
        check("out_valid", 32'(out_valid), 32'(sz > 0));
        check("count",     32'(count),     32'(sz));
        check("out_d",     out_d,          (sz > 0) ? model_q[0].d : 32'h0);
        check("out_tag",   32'(out_tag),   (sz > 0) ? 32'(model_q[0].tag) : 32'h0);
        check("out_flags", 32'(out_flags), (sz > 0) ? 32'(model_q[0].flags) : 32'h0);
        check("sticky",    32'(sticky_flags), 32'(model_sticky));
        check("cnt_inv",   32'(cnt_invalid),  32'(model_cnt_inv));
        check("cnt_inx",   32'(cnt_inexact),  32'(model_cnt_inx));
    endtask

    // Drive one cycle of inputs, check outputs before the edge, then advance
    // the model by the FIFO rules. fl is {invalid, denorm, p_lost}.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [2:0] fl,
                                 input logic [TAG_W-1:0] tag, input logic ordy,
                                 input logic clr, input logic r);
        bit     do_push;
        bit     do_pop;
        entry_t e;
        rst        = r;
        in_valid   = v;
        in_d       = d;
        in_invalid = fl[2];
        in_denorm  = fl[1];
        in_p_lost  = fl[0];
        in_tag     = tag;
        out_ready  = ordy;
        flag_clr   = clr;
        checkOutput();
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_sticky  = 3'b000;
            model_cnt_inv = 0;
            model_cnt_inx = 0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.d     = fl[2] ? 32'h8000_0000 : d;
                e.tag   = tag;
                e.flags = fl;
                model_q.push_back(e);
            end
            model_sticky = (clr ? 3'b000 : model_sticky) | (do_push ? fl : 3'b000);
            if (do_push && fl[2]) model_cnt_inv = (model_cnt_inv + 1 > CNT_MAX) ? CNT_MAX : model_cnt_inv + 1;
            if (do_push && fl[0]) model_cnt_inx = (model_cnt_inx + 1 > CNT_MAX) ? CNT_MAX : model_cnt_inx + 1;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_d = '0; in_p_lost = 1'b0; in_denorm = 1'b0;
        in_invalid = 1'b0; in_tag = '0; out_ready = 1'b0; flag_clr = 1'b0;
        model_sticky = 3'b000; model_cnt_inv = 0; model_cnt_inx = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        $display("[TB] reset released");

        // Single push of 3 with tag 5, then pop it.
        applyStimulus(1'b1, 32'd3, 3'b000, 5'd5, 1'b0, 1'b0, 1'b0);
        check("tp1_out_d", out_d, 32'd3);
        check("tp1_out_tag", 32'(out_tag), 32'd5);
        applyStimulus(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0);
        check("tp1_count", 32'(count), 32'd0);

        // Invalid result is canonicalised.
        applyStimulus(1'b1, 32'd80000000, 3'b100, 5'd1, 1'b0, 1'b0, 1'b0);
        check("tp2_out_d", out_d, 32'h8000_0000);
        check("tp2_flags", 32'(out_flags), 32'b100);
        check("tp2_sticky", 32'(sticky_flags), 32'b100);
        check("tp2_cnt_inv", 32'(cnt_invalid), 32'd1);
        applyStimulus(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0);

        // Fill to full, third push refused, then drain in order.
        applyStimulus(1'b1, 32'd7, 3'b000, 5'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd9, 3'b000, 5'd9, 1'b0, 1'b0, 1'b0);
        check("tp3_full_ready", 32'(in_ready), 32'd0);
        check("tp3_full_count", 32'(count), 32'd2);
        applyStimulus(1'b1, 32'd11, 3'b000, 5'd11, 1'b0, 1'b0, 1'b0);
        check("tp3_refused_head", out_d, 32'd7);
        applyStimulus(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0);
        check("tp3_ready_back", 32'(in_ready), 32'd1);
        check("tp3_second_head", out_d, 32'd9);
        applyStimulus(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0);

        // Push/pop together at count 1; flag_clr with a p_lost push.
        applyStimulus(1'b1, 32'd20, 3'b010, 5'd20, 1'b0, 1'b0, 1'b0);
        check("tp4_sticky_110", 32'(sticky_flags), 32'b110);
        applyStimulus(1'b1, 32'd21, 3'b001, 5'd21, 1'b1, 1'b1, 1'b0);
        check("tp4_count", 32'(count), 32'd1);
        check("tp4_head", out_d, 32'd21);
        check("tp4_sticky_001", 32'(sticky_flags), 32'b001);

        // Drive the inexact counter into saturation.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(100 + i), 3'b001, 5'(i), 1'b1, 1'b0, 1'b0);
        end
        check("tp5_cnt_sat", 32'(cnt_inexact), 32'd3);

        // Reset with two entries queued.
        applyStimulus(1'b1, 32'd50, 3'b110, 5'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1);
        check("tp6_count", 32'(count), 32'd0);
        check("tp6_valid", 32'(out_valid), 32'd0);
        check("tp6_sticky", 32'(sticky_flags), 32'd0);
        check("tp6_cnt_inx", 32'(cnt_inexact), 32'd0);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, $urandom,
                          (($urandom % 3) == 0) ? 3'($urandom) : 3'b000,
                          5'($urandom), ($urandom % 3) != 0,
                          ($urandom % 8) == 0, ($urandom % 100) == 0);
        end
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
